// File: rtl/usr_pkg.sv
// Shared types for the command-driven universal shift register.
package usr_pkg;

   // Operation codes carried on Cmd_Mode_In.
   typedef enum logic [2:0] {
      MODE_HOLD  = 3'd0,
      MODE_LOAD  = 3'd1,
      MODE_SHR   = 3'd2,
      MODE_SHL   = 3'd3,
      MODE_ASR   = 3'd4,
      MODE_ROR   = 3'd5,
      MODE_ROL   = 3'd6,
      MODE_CLEAR = 3'd7
   } usr_mode_e;

   // Control states: IDLE accepts commands, RUN executes shift steps.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } usr_state_e;

endpackage

// File: rtl/usr_param_cmd.sv
// Command-driven universal shift register, WIDTH bits wide.
// Single-cycle commands (HOLD/LOAD/CLEAR) complete on the accept edge;
// shift commands run one step per clock for Cmd_Count_In clocks.
// Optional feature macro: USR_ROTATE_EN (enables ROR/ROL; otherwise they act as HOLD).
module usr_param_cmd
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                         Clk_In,
   input  logic                         Reset_N_In,
   input  logic                         Cmd_Valid_In,
   output logic                         Cmd_Ready_Out,
   input  logic [2:0]                   Cmd_Mode_In,
   input  logic [$clog2(WIDTH+1)-1:0]   Cmd_Count_In,
   input  logic                         Serial_Data_Left_In,
   input  logic                         Serial_Data_Right_In,
   input  logic [WIDTH-1:0]             Parallel_Data_In,
   output logic [WIDTH-1:0]             Parallel_Data_Out,
   output logic                         Serial_Data_Right_Out,
   output logic                         Serial_Data_Left_Out,
   output logic                         Busy_Out,
   output logic                         Done_Out
);

   localparam int CNT_W = $clog2(WIDTH+1);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   usr_state_e        state_q, state_d;
   usr_mode_e         mode_q, mode_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [WIDTH-1:0]  reg_q, reg_d;
   logic              done_q, done_d;

   usr_mode_e         cmd_mode;
   logic              cmd_is_shift;
   logic [WIDTH-1:0]  step_val;

   assign cmd_mode = usr_mode_e'(Cmd_Mode_In);

   // Classify the incoming opcode as multi-step; rotates only count when built in.
   always_comb begin
      cmd_is_shift = 1'b0;
      case (cmd_mode)
         MODE_SHR, MODE_SHL, MODE_ASR: cmd_is_shift = 1'b1;
`ifdef USR_ROTATE_EN
         MODE_ROR, MODE_ROL:           cmd_is_shift = 1'b1;
`endif
         default:                      cmd_is_shift = 1'b0;
      endcase
   end

   // One shift step of the latched mode; serial inputs are sampled every step.
   always_comb begin
      step_val = reg_q;
      case (mode_q)
         MODE_SHR: step_val = {Serial_Data_Left_In, reg_q[WIDTH-1:1]};
         MODE_SHL: step_val = {reg_q[WIDTH-2:0], Serial_Data_Right_In};
         MODE_ASR: step_val = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
         MODE_ROR: step_val = {reg_q[0], reg_q[WIDTH-1:1]};
         MODE_ROL: step_val = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
`endif
         default:  step_val = reg_q;
      endcase
   end

   // Next-state logic: command accept in IDLE, step/countdown in RUN.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      rem_d   = rem_q;
      reg_d   = reg_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Cmd_Valid_In) begin
               if (cmd_is_shift) begin
                  if (Cmd_Count_In == '0) begin
                     done_d = 1'b1;
                  end else begin
                     mode_d  = cmd_mode;
                     rem_d   = Cmd_Count_In;
                     state_d = ST_RUN;
                  end
               end else begin
                  // HOLD, LOAD, CLEAR and (when disabled) rotates finish here.
                  done_d = 1'b1;
                  case (cmd_mode)
                     MODE_LOAD:  reg_d = Parallel_Data_In;
                     MODE_CLEAR: reg_d = '0;
                     default:    reg_d = reg_q;
                  endcase
               end
            end
         end
         ST_RUN: begin
            reg_d = step_val;
            rem_d = rem_q - CNT_ONE;
            if (rem_q == CNT_ONE) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with immediate asynchronous clear.
   always_ff @(posedge Clk_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_HOLD;
         rem_q   <= '0;
         reg_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         rem_q   <= rem_d;
         reg_q   <= reg_d;
         done_q  <= done_d;
      end
   end

   assign Cmd_Ready_Out         = (state_q == ST_IDLE);
   assign Busy_Out              = (state_q == ST_RUN);
   assign Done_Out              = done_q;
   assign Parallel_Data_Out     = reg_q;
   assign Serial_Data_Right_Out = reg_q[0];
   assign Serial_Data_Left_Out  = reg_q[WIDTH-1];

endmodule

// File: tb/tb_usr_param_cmd.sv
// Directed bench for usr_param_cmd (WIDTH = 8) with a result scoreboard:
// each command pushes its final register value, and every Done pulse pops one.
module tb_usr_param_cmd;
   import usr_pkg::*;

   localparam int WIDTH = 8;
   localparam int CNT_W = $clog2(WIDTH+1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             valid;
   logic             ready;
   logic [2:0]       mode;
   logic [CNT_W-1:0] cnt;
   logic             sl, sr;
   logic [WIDTH-1:0] pin, pout;
   logic             sdr_o, sdl_o, busy, done;

   int               nvec = 0;
   int               nerr = 0;
   logic [WIDTH-1:0] exp_q[$];

   always #5 clk = ~clk;

   usr_param_cmd #(.WIDTH(WIDTH)) dut (
      .Clk_In                (clk),
      .Reset_N_In            (rst_n),
      .Cmd_Valid_In          (valid),
      .Cmd_Ready_Out         (ready),
      .Cmd_Mode_In           (mode),
      .Cmd_Count_In          (cnt),
      .Serial_Data_Left_In   (sl),
      .Serial_Data_Right_In  (sr),
      .Parallel_Data_In      (pin),
      .Parallel_Data_Out     (pout),
      .Serial_Data_Right_Out (sdr_o),
      .Serial_Data_Left_Out  (sdl_o),
      .Busy_Out              (busy),
      .Done_Out              (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nvec++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Scoreboard consumer: every Done pulse must match the oldest pending result.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (exp_q.size() == 0) chk("done_without_cmd", exp_q.size(), 1);
         else                   chk("sb_result", pout, exp_q.pop_front());
      end
   end

   // Issue one command at the current negedge and wait (bounded) for Done.
   task automatic run_cmd(input logic [2:0] m, input logic [CNT_W-1:0] c,
                          input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] expv,
                          output int cycles);
      valid = 1'b1; mode = m; cnt = c; pin = d;
      exp_q.push_back(expv);
      @(negedge clk);
      valid = 1'b0;
      cycles = 1;
      while (done !== 1'b1 && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
      if (done !== 1'b1) chk("done_timeout", done, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] shr_tbl [4];
      logic [WIDTH-1:0] shl_tbl [6];
      logic [WIDTH-1:0] rol_exp;
      int               rol_cyc;
      int               cyc;

      shr_tbl = '{8'hA5, 8'hD2, 8'hE9, 8'hF4};
      shl_tbl = '{8'h0F, 8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE0};
`ifdef USR_ROTATE_EN
      rol_exp = 8'h03; rol_cyc = 10;
`else
      rol_exp = 8'h81; rol_cyc = 1;
`endif

      rst_n = 1'b0; valid = 1'b0; mode = 3'd0; cnt = '0; pin = '0; sl = 1'b0; sr = 1'b0;

      // Reset state
      #3;
      chk("rst_pout", pout, 8'h00);
      chk("rst_sdl", sdl_o, 0);
      chk("rst_sdr", sdr_o, 0);
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // LOAD 0xA5: single cycle, Done for one cycle, never busy
      valid = 1'b1; mode = MODE_LOAD; pin = 8'hA5; exp_q.push_back(8'hA5);
      @(negedge clk);
      valid = 1'b0;
      chk("load_pout", pout, 8'hA5);
      chk("load_done", done, 1);
      chk("load_busy", busy, 0);
      @(negedge clk);
      chk("load_done_clr", done, 0);
      chk("load_busy2", busy, 0);

      // SHR 3 with serial-left = 1
      valid = 1'b1; mode = MODE_SHR; cnt = 3; sl = 1'b1; exp_q.push_back(8'hF4);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) valid = 1'b0;
         chk("shr_pout", pout, shr_tbl[i]);
         chk("shr_busy", busy, (i < 3) ? 1 : 0);
         chk("shr_ready", ready, (i < 3) ? 0 : 1);
         chk("shr_done", done, (i == 3) ? 1 : 0);
      end
      chk("shr_sdl", sdl_o, 1);
      chk("shr_sdr", sdr_o, 0);
      sl = 1'b0;

      // ASR 2 on 0x80
      run_cmd(MODE_LOAD, 0, 8'h80, 8'h80, cyc);
      run_cmd(MODE_ASR, 2, 8'h00, 8'hE0, cyc);
      chk("asr_cycles", cyc, 3);

      // ROL 9 on 0x81 (wraps modulo WIDTH when rotates exist)
      run_cmd(MODE_LOAD, 0, 8'h81, 8'h81, cyc);
      run_cmd(MODE_ROL, 9, 8'h00, rol_exp, cyc);
      chk("rol_cycles", cyc, rol_cyc);

      // CLEAR
      run_cmd(MODE_CLEAR, 0, 8'hFF, 8'h00, cyc);
      chk("clr_cycles", cyc, 1);

      // SHL 5 on 0x0F with a second command held valid during RUN
      run_cmd(MODE_LOAD, 0, 8'h0F, 8'h0F, cyc);
      valid = 1'b1; mode = MODE_SHL; cnt = 5; sr = 1'b0; exp_q.push_back(8'hE0);
      @(negedge clk);
      mode = MODE_LOAD; pin = 8'h77; exp_q.push_back(8'h77);
      chk("shl_pout", pout, shl_tbl[0]);
      chk("shl_ready", ready, 0);
      for (int i = 1; i < 6; i++) begin
         @(negedge clk);
         chk("shl_pout", pout, shl_tbl[i]);
         chk("shl_ready", ready, (i == 5) ? 1 : 0);
         chk("shl_done", done, (i == 5) ? 1 : 0);
      end
      @(negedge clk);
      valid = 1'b0;
      chk("held_pout", pout, 8'h77);
      chk("held_done", done, 1);
      @(negedge clk);
      chk("held_done_clr", done, 0);

      // SHL 5 interrupted by reset after step 2
      run_cmd(MODE_LOAD, 0, 8'h0F, 8'h0F, cyc);
      valid = 1'b1; mode = MODE_SHL; cnt = 5; exp_q.push_back(8'hE0);
      @(negedge clk); valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rstmid_step2", pout, 8'h3C);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_pout", pout, 8'h00);
      chk("rstmid_ready", ready, 1);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_done", done, 0);
      exp_q.delete();
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rstmid_no_done", done, 0);
         chk("rstmid_hold", pout, 8'h00);
      end

      // SHL count 0: no change, Done next cycle
      run_cmd(MODE_LOAD, 0, 8'h3C, 8'h3C, cyc);
      run_cmd(MODE_SHL, 0, 8'h00, 8'h3C, cyc);
      chk("shl0_cycles", cyc, 1);
      chk("shl0_busy", busy, 0);

      // Back-to-back LOADs
      @(negedge clk);
      valid = 1'b1; mode = MODE_LOAD; pin = 8'h11; exp_q.push_back(8'h11);
      @(negedge clk);
      chk("b2b_pout1", pout, 8'h11);
      chk("b2b_done1", done, 1);
      pin = 8'h22; exp_q.push_back(8'h22);
      @(negedge clk);
      valid = 1'b0;
      chk("b2b_pout2", pout, 8'h22);
      chk("b2b_done2", done, 1);
      @(negedge clk);
      chk("b2b_done_clr", done, 0);

      chk("sb_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
